// File: rtl/bus_arbiter8_rr.sv
// Round-robin arbiter for 8 requesters sharing one 16-bit bus; drives the mux select,
// a one-hot grant and a bus-valid qualifier, with a bounded hold when others wait.
module bus_arbiter8_rr #(
  parameter int MAX_HOLD = 4,
  parameter int CNT_W    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic [2:0] sel,
  output logic       bus_valid,
  output logic       preempt
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [CNT_W-1:0] HoldMax = CNT_W'(MAX_HOLD);

  state_t           state_q, state_d;
  logic [2:0]       ptr_q, ptr_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic [7:0]       gnt_q, gnt_d;
  logic [2:0]       sel_q, sel_d;
  logic             valid_q, valid_d;
  logic             preempt_q, preempt_d;

  // Returns {found, index} of the first set bit scanning base, base+1, ... mod 8.
  function automatic logic [3:0] rrPick(input logic [7:0] r, input logic [2:0] base);
    logic [3:0] res;
    logic [2:0] idx;
    res = 4'd0;
    for (int i = 7; i >= 0; i--) begin
      idx = base + 3'(i);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  logic [2:0] owner;
  logic [7:0] others;
  logic [3:0] pickIdle;
  logic [3:0] pickNext;

  assign owner    = sel_q;
  assign others   = req & ~(8'b1 << owner);
  assign pickIdle = rrPick(req, ptr_q);
  assign pickNext = rrPick(others, owner + 3'd1);

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    gnt_d     = gnt_q;
    sel_d     = sel_q;
    valid_d   = valid_q;
    preempt_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (pickIdle[3]) begin
          gnt_d   = 8'b1 << pickIdle[2:0];
          sel_d   = pickIdle[2:0];
          valid_d = 1'b1;
          hold_d  = CNT_W'(1);
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (!req[owner]) begin
          ptr_d = owner + 3'd1;
          if (pickNext[3]) begin
            gnt_d  = 8'b1 << pickNext[2:0];
            sel_d  = pickNext[2:0];
            hold_d = CNT_W'(1);
          end else begin
            gnt_d   = 8'h00;
            valid_d = 1'b0;
            hold_d  = '0;
            state_d = IDLE;
          end
        end else if (hold_q == HoldMax && pickNext[3]) begin
          // Hold limit reached with a competitor waiting: hand the bus over.
          ptr_d     = owner + 3'd1;
          gnt_d     = 8'b1 << pickNext[2:0];
          sel_d     = pickNext[2:0];
          hold_d    = CNT_W'(1);
          preempt_d = 1'b1;
        end else if (hold_q != HoldMax) begin
          hold_d = hold_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= 3'd0;
      hold_q    <= '0;
      gnt_q     <= 8'h00;
      sel_q     <= 3'd0;
      valid_q   <= 1'b0;
      preempt_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      gnt_q     <= gnt_d;
      sel_q     <= sel_d;
      valid_q   <= valid_d;
      preempt_q <= preempt_d;
    end
  end

  assign gnt       = gnt_q;
  assign sel       = sel_q;
  assign bus_valid = valid_q;
  assign preempt   = preempt_q;

endmodule

// File: doc/bus_arbiter8_rr.md
Name: bus_arbiter8_rr

Overview:
- Round-robin arbiter sharing one 16-bit datapath bus among 8 requesters.
- Produces the 3-bit select consumed by the 8:1 16-bit operand/bus multiplexer, a one-hot grant and a bus-valid qualifier.
- Each grant is held while the owner keeps requesting, bounded by a hold limit when others are waiting.
- Sits between requesting units (ALU ports, memory port, register-file write-back sources) and the shared mux.

Parameters:
- MAX_HOLD, 4, maximum consecutive cycles one owner may keep the bus while another requester is pending (legal 1..15).
- CNT_W, 4, width of internal hold counter; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  input  1  system clock, all state rises on posedge.
- rst  input  1  asynchronous, active-high reset.
- req  input  8  request per requester; bit i = requester i.
- gnt  output  8  one-hot registered grant; all-zero when bus idle.
- sel  output  3  binary index of current/last owner, drives mux select.
- bus_valid  output  1  high when gnt is non-zero (bus data is owned and meaningful).
- preempt  output  1  one-cycle registered pulse: previous grant ended by hold-limit preemption.

Behaviour:
- Reset (async, rst=1): gnt=8'h00, sel=3'd0, bus_valid=0, preempt=0, state=IDLE, ptr=0, hold_cnt=0. Outputs update immediately on rst assertion, independent of clk. Release takes effect on the next posedge.
- Outputs registered; no combinational path from req to any output.
- ptr: 3-bit priority pointer. Search order is ptr, ptr+1, ..., ptr+7, mod 8.
- State IDLE:
  - If req != 0: winner = first set bit in search order. Next edge: gnt=1<<winner, sel=winner, bus_valid=1, hold_cnt=1, state=GRANT.
  - Else all outputs hold, except preempt=0.
  - Latency: req sampled at edge N gives grant visible after edge N (1 cycle).
- State GRANT, owner o:
  - Release (req[o]=0): search from o+1, excluding o.
    - If a winner w is found: next edge gnt=1<<w, sel=w, hold_cnt=1; back-to-back, no idle bubble.
    - Else: gnt=0, bus_valid=0, sel keeps o, state=IDLE.
    - Either way ptr=o+1 and preempt=0.
  - Preempt (req[o]=1, hold_cnt==MAX_HOLD, another req bit set): switch to winner found from o+1, hold_cnt=1, ptr=o+1, preempt=1 for one cycle.
  - Continue (req[o]=1, otherwise): hold_cnt increments, saturating at MAX_HOLD. With no other requester pending, owner keeps the bus indefinitely; preempt=0.
- ptr only updates on release/preemption, so a just-served requester has lowest priority next round (fairness; max wait = 7*MAX_HOLD cycles for a continuously requesting unit).
- MAX_HOLD=1: every cycle with competing requests rotates.
- Simultaneous release by owner and new requests: treated as release with back-to-back handoff.
- Owner index set again in same cycle it drops: ignored until its turn in search order (excluded from that arbitration).
- Reset mid-grant: grant removed asynchronously; after release, arbitration restarts from ptr=0.
- gnt always one-hot or zero; sel == index of gnt bit whenever bus_valid=1.

Test Plan:
- Reset/idle: assert rst mid-cycle with gnt=8'h04 -> gnt=0, sel=0, bus_valid=0 immediately. Release with req=0 for 5 cycles -> outputs unchanged.
- Single requester: req=8'h20 from edge 1 -> gnt=8'h20, sel=5, bus_valid=1 after edge 1. Held 10 cycles with preempt=0. Drop req -> gnt=0 next edge, sel stays 5.
- Round-robin from reset: req=8'h81 held, owners release after 1 cycle each and re-request -> grant order 0,7,0,7 with back-to-back handoff and no idle cycle.
- Preemption (MAX_HOLD=4): req[2] held continuously, req[6] raised at grant cycle 2 -> requester 2 owns 4 cycles, then gnt=8'h40, sel=6, preempt=1 for exactly one cycle. ptr=3, so 6 still wins next.
- Wrap/priority: owner 6 releases with req=8'h05 -> winner 0 (search 7,0,...), gnt=8'h01. Next release with req=8'h04 -> gnt=8'h04.
- All-request fairness: req=8'hFF for 64 cycles, MAX_HOLD=4 -> each index granted exactly twice in order 0..7,0..7. One-hot assertion never fails.
